// File: rtl/sync_master_ctrl.sv
// Lock controller for the 4-phase oversampling data-recovery block: sequences its reset,
// declares lock on a stable phase, detects loss (bad phase vector, SRL limit, phase hopping).
module sync_master_ctrl #(
  parameter int RST_CYCLES  = 16,
  parameter int LOCK_CNT    = 256,
  parameter int ACQ_TIMEOUT = 4096,
  parameter int HOP_WINDOW  = 1024,
  parameter int MAX_HOPS    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] use_in,
  input  logic [1:0] ctrl_in,
  input  logic       clr_cnt,
  output logic       sm_rst,
  output logic       locked,
  output logic [1:0] phase,
  output logic [7:0] lost_cnt,
  output logic [2:0] state
);

  localparam int RW = $clog2(RST_CYCLES) + 1;
  localparam int SW = $clog2(LOCK_CNT) + 1;
  localparam int AW = $clog2(ACQ_TIMEOUT) + 1;
  localparam int WW = $clog2(HOP_WINDOW) + 1;
  localparam int HW = $clog2(MAX_HOPS) + 1;

  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [SW-1:0] STAB_LOCK = SW'(LOCK_CNT);
  localparam logic [AW-1:0] ACQ_LIMIT = AW'(ACQ_TIMEOUT);
  localparam logic [WW-1:0] WIN_LAST  = WW'(HOP_WINDOW - 1);
  localparam logic [HW-1:0] HOP_LIMIT = HW'(MAX_HOPS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RESET   = 3'd1,
    ACQUIRE = 3'd2,
    LOCKED  = 3'd3,
    LOST    = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      use_q, use_prev_q;
  logic [1:0]      ctrl_q;
  logic [RW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [SW-1:0]   stab_q, stab_d;
  logic [AW-1:0]   acq_q, acq_d;
  logic [WW-1:0]   win_q, win_d;
  logic [HW-1:0]   hops_q, hops_d;
  logic            sm_rst_q, sm_rst_d;
  logic            locked_q, locked_d;
  logic [1:0]      phase_q, phase_d;
  logic [7:0]      lost_q, lost_d;

  logic            valid, prev_valid, hop, ctrl_limit, wrap, hop_excess;
  logic [1:0]      use_enc;
  logic [HW-1:0]   hops_base;

  assign valid      = (use_q != 4'd0) && ((use_q & (use_q - 4'd1)) == 4'd0);
  assign prev_valid = (use_prev_q != 4'd0) && ((use_prev_q & (use_prev_q - 4'd1)) == 4'd0);
  assign hop        = valid && prev_valid && (use_q != use_prev_q);
  assign ctrl_limit = (ctrl_q == 2'd0) || (ctrl_q == 2'd3);
  // First cycle of each hop window; a hop here starts the new window's count.
  assign wrap       = (win_q == '0);
  assign hops_base  = wrap ? '0 : hops_q;
  assign hop_excess = hop && (hops_base >= HOP_LIMIT);

  always_comb begin
    use_enc = 2'd0;
    case (use_q)
      4'b0010: use_enc = 2'd1;
      4'b0100: use_enc = 2'd2;
      4'b1000: use_enc = 2'd3;
      default: use_enc = 2'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    stab_d    = stab_q;
    acq_d     = acq_q;
    win_d     = win_q;
    hops_d    = hops_q;
    phase_d   = phase_q;
    lost_d    = lost_q;

    case (state_q)
      IDLE: state_d = RESET;
      RESET: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d   = ACQUIRE;
          rst_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end
      ACQUIRE: begin
        if (!valid)                  stab_d = '0;
        else if (use_q != use_prev_q) stab_d = SW'(1);
        else                         stab_d = stab_q + SW'(1);
        acq_d = acq_q + AW'(1);
        if (stab_d == STAB_LOCK) begin
          state_d = LOCKED;
          phase_d = use_enc;
          stab_d  = '0;
          acq_d   = '0;
        end else if (acq_d == ACQ_LIMIT) begin
          state_d = RESET;
          stab_d  = '0;
          acq_d   = '0;
        end
      end
      LOCKED: begin
        win_d  = (win_q == WIN_LAST) ? '0 : win_q + WW'(1);
        hops_d = hops_base + HW'(hop);
        if (!valid || ctrl_limit || hop_excess) begin
          state_d = LOST;
          win_d   = '0;
          hops_d  = '0;
        end else if (hop) begin
          phase_d = use_enc;
        end
      end
      LOST: begin
        state_d = RESET;
        lost_d  = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase

    if (clr_cnt) lost_d = '0;

    // Disable overrides every transition; the loss counter is only touched by clr_cnt.
    if (!enable) begin
      state_d   = IDLE;
      rst_cnt_d = '0;
      stab_d    = '0;
      acq_d     = '0;
      win_d     = '0;
      hops_d    = '0;
      lost_d    = clr_cnt ? '0 : lost_q;
    end

    sm_rst_d = !((state_d == ACQUIRE) || (state_d == LOCKED));
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      use_q      <= '0;
      use_prev_q <= '0;
      ctrl_q     <= '0;
      rst_cnt_q  <= '0;
      stab_q     <= '0;
      acq_q      <= '0;
      win_q      <= '0;
      hops_q     <= '0;
      sm_rst_q   <= 1'b1;
      locked_q   <= 1'b0;
      phase_q    <= '0;
      lost_q     <= '0;
    end else begin
      state_q    <= state_d;
      use_q      <= use_in;
      use_prev_q <= use_q;
      ctrl_q     <= ctrl_in;
      rst_cnt_q  <= rst_cnt_d;
      stab_q     <= stab_d;
      acq_q      <= acq_d;
      win_q      <= win_d;
      hops_q     <= hops_d;
      sm_rst_q   <= sm_rst_d;
      locked_q   <= locked_d;
      phase_q    <= phase_d;
      lost_q     <= lost_d;
    end
  end

  assign sm_rst   = sm_rst_q;
  assign locked   = locked_q;
  assign phase    = phase_q;
  assign lost_cnt = lost_q;
  assign state    = state_q;

endmodule
